matmul_apb_slave: RTL

// APB slave front-end of matmul_calc; sits directly downstream of the APB master/stimulus.

---
 rtl/matmul_apb_slave.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_apb_slave.sv
// APB register front-end for the matmul core: operand rows, control/status, result reads.
// Define MATMUL_APB_TIMEOUT_EN to bound result reads by TIMEOUT_CYC cycles.
module matmul_apb_slave #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_DIM     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             psel_i,
    input  logic                             penable_i,
    input  logic                             pwrite_i,
    input  logic [BUS_WIDTH/8-1:0]           pstrb_i,
    input  logic [ADDR_WIDTH-1:0]            paddr_i,
    input  logic [BUS_WIDTH-1:0]             pwdata_i,
    output logic                             pready_o,
    output logic                             pslverr_o,
    output logic [BUS_WIDTH-1:0]             prdata_o,
    input  logic                             busy_i,
    input  logic                             done_i,
    output logic                             start_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]     a_rows_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]     b_rows_o,
    output logic                             res_rd_o,
    output logic [$clog2(MAX_DIM*MAX_DIM)-1:0] res_idx_o,
    input  logic                             res_valid_i,
    input  logic [BUS_WIDTH-1:0]             res_data_i
);

    localparam int STRB_W   = BUS_WIDTH / 8;
    localparam int ROW_BITS = MAX_DIM * DATA_WIDTH;
    localparam int RES_N    = MAX_DIM * MAX_DIM;
    localparam int RX_W     = $clog2(RES_N);
    localparam int RI_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int WW       = ADDR_WIDTH - 2;

    localparam logic [WW-1:0] W_CTRL = WW'(0);
    localparam logic [WW-1:0] W_STAT = WW'(1);
    localparam logic [WW-1:0] W_A    = WW'(8);
    localparam logic [WW-1:0] W_B    = WW'(16);
    localparam logic [WW-1:0] W_RES  = WW'(64);
    localparam logic [WW-1:0] W_DIM  = WW'(MAX_DIM);
    localparam logic [WW-1:0] W_RN   = WW'(RES_N);

    function automatic logic [BUS_WIDTH-1:0] row_mask();
        logic [BUS_WIDTH-1:0] m;
        for (int i = 0; i < BUS_WIDTH; i++) m[i] = (i < ROW_BITS);
        return m;
    endfunction

    localparam logic [BUS_WIDTH-1:0] ROW_MASK = row_mask();

    function automatic logic [BUS_WIDTH-1:0] merge(
        input logic [BUS_WIDTH-1:0] old,
        input logic [STRB_W-1:0]    strb,
        input logic [BUS_WIDTH-1:0] data
    );
        logic [BUS_WIDTH-1:0] r;
        r = old;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r & ROW_MASK;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT_RES, S_RESP} state_t;
    typedef enum logic [2:0] {T_NONE, T_CTRL, T_STAT, T_A, T_B, T_RES} tgt_t;

    state_t               state_q, state_d;
    tgt_t                 tgt_q, dec_tgt;
    logic [RX_W-1:0]      dec_idx, res_idx_q;
    logic [RI_W-1:0]      row_q;
    logic                 write_q, err_q, done_q, start_q, res_rd_q;
    logic [BUS_WIDTH-1:0] res_q, rd_word;
    logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
    logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
    logic [WW-1:0]        word;
    logic                 setup, setup_err, res_go, xfer;
    logic                 start_req, busy_err, acc_err, commit;
    logic                 tmo, tmo_q;

    assign word = paddr_i[ADDR_WIDTH-1:2];

    always_comb begin
        dec_tgt = T_NONE;
        dec_idx = '0;
        unique case (1'b1)
            (word == W_CTRL): dec_tgt = T_CTRL;
            (word == W_STAT): dec_tgt = T_STAT;
            (word >= W_A && word < W_A + W_DIM): begin
                dec_tgt = T_A;
                dec_idx = RX_W'(word - W_A);
            end
            (word >= W_B && word < W_B + W_DIM): begin
                dec_tgt = T_B;
                dec_idx = RX_W'(word - W_B);
            end
            (word >= W_RES && word < W_RES + W_RN): begin
                dec_tgt = T_RES;
                dec_idx = RX_W'(word - W_RES);
            end
            default: ;
        endcase
        if (paddr_i[1:0] != 2'b00) dec_tgt = T_NONE;
    end

    assign setup     = (state_q == S_IDLE) & psel_i & ~penable_i;
    assign setup_err = (dec_tgt == T_NONE)
                     | ((dec_tgt == T_RES) & (pwrite_i | busy_i));
    assign res_go    = (dec_tgt == T_RES) & ~pwrite_i & ~busy_i;
    assign xfer      = psel_i & penable_i;

    assign start_req = pstrb_i[0] & pwdata_i[0];
    assign busy_err  = write_q & busy_i
                     & ((tgt_q == T_A) | (tgt_q == T_B)
                        | ((tgt_q == T_CTRL) & start_req));
    assign acc_err   = err_q | busy_err;
    assign commit    = (state_q == S_ACCESS) & xfer & write_q & ~acc_err;

    always_comb begin
        rd_word = '0;
        unique case (tgt_q)
            T_STAT:  rd_word = BUS_WIDTH'({done_q, busy_i});
            T_A:     rd_word = a_q[row_q];
            T_B:     rd_word = b_q[row_q];
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (setup) state_d = res_go ? S_WAIT_RES : S_ACCESS;
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                if (xfer) begin
                    pready_o  = 1'b1;
                    pslverr_o = acc_err;
                    if (!write_q && !acc_err) prdata_o = rd_word;
                end
            end
            S_WAIT_RES: begin
                if (!xfer) state_d = S_IDLE;
                else if (res_valid_i || tmo) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (xfer) begin
                    pready_o  = 1'b1;
                    pslverr_o = tmo_q;
                    prdata_o  = tmo_q ? '0 : res_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            tgt_q     <= T_NONE;
            row_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            res_idx_q <= '0;
            res_rd_q  <= 1'b0;
            res_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < MAX_DIM; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            res_rd_q <= 1'b0;
            start_q  <= 1'b0;
            if (setup) begin
                tgt_q   <= dec_tgt;
                row_q   <= dec_idx[RI_W-1:0];
                write_q <= pwrite_i;
                err_q   <= setup_err;
                if (res_go) begin
                    res_rd_q  <= 1'b1;
                    res_idx_q <= dec_idx;
                end
            end
            if (state_q == S_WAIT_RES && xfer && res_valid_i)
                res_q <= res_data_i;
            if (commit) begin
                unique case (tgt_q)
                    T_A:     a_q[row_q] <= merge(a_q[row_q], pstrb_i, pwdata_i);
                    T_B:     b_q[row_q] <= merge(b_q[row_q], pstrb_i, pwdata_i);
                    T_CTRL:  start_q <= start_req;
                    default: ;
                endcase
            end
            // a completion pulse wins over a same-cycle clear
            if (done_i)
                done_q <= 1'b1;
            else if (start_q || (commit && tgt_q == T_STAT
                                 && pstrb_i[0] && pwdata_i[1]))
                done_q <= 1'b0;
        end
    end

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;

    assign tmo = (state_q == S_WAIT_RES) & ~res_valid_i
               & (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (setup) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else if (state_q == S_WAIT_RES) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == S_WAIT_RES && xfer && tmo) tmo_q <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign tmo_q = 1'b0;
`endif

    always_comb begin
        a_rows_o = '0;
        b_rows_o = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            a_rows_o[i*BUS_WIDTH +: BUS_WIDTH] = a_q[i];
            b_rows_o[i*BUS_WIDTH +: BUS_WIDTH] = b_q[i];
        end
    end

    assign start_o   = start_q;
    assign res_rd_o  = res_rd_q;
    assign res_idx_o = res_idx_q;

endmodule
